// File: rtl/sim_ctrl_monitor.sv
// Top-level simulation controller: counts cycles, emits heartbeats, collects finish/fail
// requests from NUM_SRC channels, runs a watchdog and drains before declaring a verdict.
module sim_ctrl_monitor #(
  parameter int NUM_SRC      = 4,
  parameter int CNT_W        = 32,
  parameter int HEARTBEAT    = 1000,
  parameter int TIMEOUT      = 0,
  parameter int DRAIN_CYCLES = 4,
  parameter int USE_FINISH   = 1,
  parameter int VERBOSE      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] finish_req,
  input  logic [NUM_SRC-1:0] fail_req,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               heartbeat,
  output logic               running,
  output logic               draining,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [NUM_SRC-1:0] fail_src,
  output logic [NUM_SRC-1:0] finish_src
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int HB_W = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [HB_W-1:0]  HB_LAST  = (HEARTBEAT > 0) ? HB_W'(HEARTBEAT - 1) : {HB_W{1'b0}};
  localparam logic [DR_W-1:0]  DR_LOAD  = DR_W'(DRAIN_CYCLES);
  localparam logic [DR_W-1:0]  DR_ONE   = DR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [HB_W-1:0]  HB_ONE   = HB_W'(1'b1);

  state_t               state_r;
  logic [CNT_W-1:0]     cycle_count_r;
  logic [HB_W-1:0]      hb_cnt_r;
  logic [DR_W-1:0]      drain_cnt_r;
  logic                 heartbeat_r;
  logic                 draining_r;
  logic                 done_r;
  logic                 pass_r;
  logic                 timeout_r;
  logic [NUM_SRC-1:0]   fail_src_r;
  logic [NUM_SRC-1:0]   finish_src_r;

  state_t               state_next_s;
  logic                 active_s;
  logic                 any_finish_s;
  logic                 any_fail_s;
  logic                 trig_timeout_s;
  logic                 trigger_s;
  logic                 drain_last_s;
  logic                 enter_done_s;
  logic                 hb_wrap_s;
  logic                 pass_next_s;
  logic                 timeout_next_s;
  logic [CNT_W-1:0]     cycle_count_next_s;
  logic [NUM_SRC-1:0]   fail_src_next_s;

  // Trigger detection, next-state and next-value computation
  always_comb begin
    active_s       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    any_finish_s   = |finish_req;
    any_fail_s     = |fail_req;
    // The watchdog only fires on a quiet cycle; a real request takes precedence.
    trig_timeout_s = (TIMEOUT > 0) && (state_r == ST_RUN) && (cycle_count_r == TO_LAST)
                     && !any_finish_s && !any_fail_s;
    trigger_s      = (state_r == ST_RUN) && (any_finish_s || any_fail_s || trig_timeout_s);
    drain_last_s   = (state_r == ST_DRAIN) && (drain_cnt_r <= DR_ONE);
    hb_wrap_s      = (HEARTBEAT > 0) && active_s && (hb_cnt_r == HB_LAST);

    if (active_s) begin
      cycle_count_next_s = (cycle_count_r == CNT_MAX) ? cycle_count_r : (cycle_count_r + CNT_ONE);
      fail_src_next_s    = fail_src_r | fail_req;
    end else begin
      cycle_count_next_s = cycle_count_r;
      fail_src_next_s    = fail_src_r;
    end

    timeout_next_s = timeout_r | trig_timeout_s;
    pass_next_s    = (fail_src_next_s == {NUM_SRC{1'b0}}) && !timeout_next_s;

    case (state_r)
      ST_RUN: begin
        if (trigger_s) begin
          state_next_s = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: state_next_s = ST_DONE;
      default: state_next_s = ST_RUN;
    endcase

    enter_done_s = (state_next_s == ST_DONE) && (state_r != ST_DONE);
  end

  // Controller state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      cycle_count_r <= {CNT_W{1'b0}};
      hb_cnt_r      <= {HB_W{1'b0}};
      drain_cnt_r   <= {DR_W{1'b0}};
      heartbeat_r   <= 1'b0;
      draining_r    <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      timeout_r     <= 1'b0;
      fail_src_r    <= {NUM_SRC{1'b0}};
      finish_src_r  <= {NUM_SRC{1'b0}};
    end else begin
      state_r       <= state_next_s;
      cycle_count_r <= cycle_count_next_s;
      fail_src_r    <= fail_src_next_s;
      timeout_r     <= timeout_next_s;
      heartbeat_r   <= hb_wrap_s;
      draining_r    <= (state_next_s == ST_DRAIN);
      done_r        <= (state_next_s == ST_DONE);

      if (trigger_s) begin
        finish_src_r <= finish_req;
      end else begin
        finish_src_r <= finish_src_r;
      end

      if (trigger_s) begin
        drain_cnt_r <= DR_LOAD;
      end else if ((state_r == ST_DRAIN) && (drain_cnt_r != {DR_W{1'b0}})) begin
        drain_cnt_r <= drain_cnt_r - DR_ONE;
      end else begin
        drain_cnt_r <= drain_cnt_r;
      end

      if (hb_wrap_s) begin
        hb_cnt_r <= {HB_W{1'b0}};
      end else if ((HEARTBEAT > 0) && active_s) begin
        hb_cnt_r <= hb_cnt_r + HB_ONE;
      end else begin
        hb_cnt_r <= hb_cnt_r;
      end

      if (enter_done_s) begin
        pass_r <= pass_next_s;
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign running     = (state_r == ST_RUN);
  assign cycle_count = cycle_count_r;
  assign heartbeat   = heartbeat_r;
  assign draining    = draining_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign timeout     = timeout_r;
  assign fail_src    = fail_src_r;
  assign finish_src  = finish_src_r;

`ifndef SYNTHESIS
  // Start-of-simulation banner
  initial begin
    $display("[%0t] Model running...", $time);
  end

  // Messages use the values being registered on this edge so they match what the outputs will show
  always @(posedge clk) begin
    if (rst_n && (VERBOSE != 0)) begin
      if (hb_wrap_s) begin
        $display("[%0d] heartbeat", cycle_count_next_s);
      end
      if (trigger_s) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (finish_req[i]) $display("[%0d] finish request on channel %0d", cycle_count_r, i);
          if (fail_req[i])   $display("[%0d] fail request on channel %0d", cycle_count_r, i);
        end
        if (trig_timeout_s) $display("[%0d] watchdog timeout", cycle_count_r);
      end
      if (enter_done_s) begin
        $display("[%0d] simulation done: %s fail_src=%b timeout=%0d",
                 cycle_count_next_s, pass_next_s ? "PASS" : "FAIL", fail_src_next_s, timeout_next_s);
      end
    end
    if (rst_n && (USE_FINISH != 0) && enter_done_s) begin
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Directed bench for sim_ctrl_monitor: four instances with different parameter sets share one
// clock, reset and request bus; each scenario checks only the instance it targets.
module tb_sim_ctrl_monitor;

  logic       clk;
  logic       rst_n;
  logic [3:0] finish_req;
  logic [3:0] fail_req;

  logic [31:0] cnt_a, cnt_b, cnt_d;
  logic [3:0]  cnt_c;
  logic        hb_a, run_a, drn_a, done_a, pass_a, to_a;
  logic        hb_b, run_b, drn_b, done_b, pass_b, to_b;
  logic        hb_c, run_c, drn_c, done_c, pass_c, to_c;
  logic        hb_d, run_d, drn_d, done_d, pass_d, to_d;
  logic [3:0]  fsrc_a, fin_a, fsrc_b, fin_b, fsrc_c, fin_c, fsrc_d, fin_d;

  int n_pass;
  int n_total;
  int hb_seen;

  sim_ctrl_monitor #(.NUM_SRC(4), .CNT_W(32), .HEARTBEAT(4), .TIMEOUT(0), .DRAIN_CYCLES(4),
                     .USE_FINISH(0), .VERBOSE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .finish_req(finish_req), .fail_req(fail_req),
    .cycle_count(cnt_a), .heartbeat(hb_a), .running(run_a), .draining(drn_a), .done(done_a),
    .pass(pass_a), .timeout(to_a), .fail_src(fsrc_a), .finish_src(fin_a));

  sim_ctrl_monitor #(.NUM_SRC(4), .CNT_W(32), .HEARTBEAT(0), .TIMEOUT(50), .DRAIN_CYCLES(4),
                     .USE_FINISH(0), .VERBOSE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .finish_req(finish_req), .fail_req(fail_req),
    .cycle_count(cnt_b), .heartbeat(hb_b), .running(run_b), .draining(drn_b), .done(done_b),
    .pass(pass_b), .timeout(to_b), .fail_src(fsrc_b), .finish_src(fin_b));

  sim_ctrl_monitor #(.NUM_SRC(4), .CNT_W(4), .HEARTBEAT(0), .TIMEOUT(0), .DRAIN_CYCLES(4),
                     .USE_FINISH(0), .VERBOSE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .finish_req(finish_req), .fail_req(fail_req),
    .cycle_count(cnt_c), .heartbeat(hb_c), .running(run_c), .draining(drn_c), .done(done_c),
    .pass(pass_c), .timeout(to_c), .fail_src(fsrc_c), .finish_src(fin_c));

  sim_ctrl_monitor #(.NUM_SRC(4), .CNT_W(32), .HEARTBEAT(0), .TIMEOUT(0), .DRAIN_CYCLES(0),
                     .USE_FINISH(0), .VERBOSE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .finish_req(finish_req), .fail_req(fail_req),
    .cycle_count(cnt_d), .heartbeat(hb_d), .running(run_d), .draining(drn_d), .done(done_d),
    .pass(pass_d), .timeout(to_d), .fail_src(fsrc_d), .finish_src(fin_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    finish_req = 4'b0000;
    fail_req   = 4'b0000;
    rst_n      = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    finish_req = 4'b0000;
    fail_req   = 4'b0000;

    // Reset values, including while reset is still held
    #2;
    check_eq("rst_cnt_async", cnt_a, 32'd0);
    check_eq("rst_run_async", {31'd0, run_a}, 32'd1);
    do_reset();
    check_eq("rst_cnt", cnt_a, 32'd0);
    check_eq("rst_flags", {26'd0, hb_a, drn_a, done_a, pass_a, to_a, run_a}, 32'b000001);
    check_eq("rst_fsrc", {28'd0, fsrc_a}, 32'd0);
    check_eq("rst_fin", {28'd0, fin_a}, 32'd0);

    // Heartbeat every 4 cycles, no requests
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      check_eq($sformatf("hb_c%0d", i), {31'd0, hb_a}, (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    check_eq("hb_cnt20", cnt_a, 32'd20);
    check_eq("hb_running", {31'd0, run_a}, 32'd1);
    check_eq("hb_notdone", {31'd0, done_a}, 32'd0);

    // Normal finish on channel 2 at cycle 10
    do_reset();
    tick(10);
    finish_req = 4'b0100;
    tick(1);
    finish_req = 4'b0000;
    check_eq("fin_cnt11", cnt_a, 32'd11);
    check_eq("fin_drain11", {30'd0, drn_a, run_a}, 32'b10);
    for (int c = 12; c <= 14; c++) begin
      tick(1);
      check_eq($sformatf("fin_drain%0d", c), {30'd0, drn_a, done_a}, 32'b10);
    end
    tick(1);
    check_eq("fin_cnt15", cnt_a, 32'd15);
    check_eq("fin_done", {29'd0, done_a, drn_a, pass_a}, 32'b101);
    check_eq("fin_src", {28'd0, fin_a}, 32'b0100);
    check_eq("fin_fsrc", {28'd0, fsrc_a}, 32'd0);
    tick(3);
    check_eq("fin_frozen", cnt_a, 32'd15);
    check_eq("fin_sticky", {31'd0, done_a}, 32'd1);

    // Simultaneous finish and fail, then a further fail during drain
    do_reset();
    tick(5);
    finish_req = 4'b0001;
    fail_req   = 4'b1000;
    tick(1);
    finish_req = 4'b0010;
    fail_req   = 4'b0010;
    tick(1);
    finish_req = 4'b0000;
    fail_req   = 4'b0000;
    tick(3);
    check_eq("mix_cnt", cnt_a, 32'd10);
    check_eq("mix_done_pass", {30'd0, done_a, pass_a}, 32'b10);
    check_eq("mix_fsrc", {28'd0, fsrc_a}, 32'b1010);
    check_eq("mix_fin", {28'd0, fin_a}, 32'b0001);
    check_eq("mix_to", {31'd0, to_a}, 32'd0);
    fail_req = 4'b0100;
    tick(1);
    fail_req = 4'b0000;
    check_eq("mix_done_ignored", {28'd0, fsrc_a}, 32'b1010);

    // Watchdog at cycle 50 on the TIMEOUT=50 instance
    do_reset();
    tick(49);
    check_eq("to_pre", {30'd0, to_b, run_b}, 32'b01);
    tick(1);
    check_eq("to_cnt50", cnt_b, 32'd50);
    check_eq("to_fired", {30'd0, to_b, drn_b}, 32'b11);
    check_eq("to_disabled_a", {31'd0, to_a}, 32'd0);
    tick(3);
    check_eq("to_notyet", {31'd0, done_b}, 32'd0);
    tick(1);
    check_eq("to_cnt54", cnt_b, 32'd54);
    check_eq("to_done", {27'd0, done_b, pass_b, run_b, drn_b, hb_b}, 32'b10000);
    check_eq("to_fsrc", {28'd0, fsrc_b}, 32'd0);
    check_eq("to_fin", {28'd0, fin_b}, 32'd0);

    // Asynchronous reset in the middle of drain, then a clean restart
    do_reset();
    tick(10);
    finish_req = 4'b0100;
    tick(1);
    finish_req = 4'b0000;
    tick(1);
    check_eq("rd_drain12", {31'd0, drn_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rd_async_cnt", cnt_a, 32'd0);
    check_eq("rd_async_flags", {26'd0, hb_a, drn_a, done_a, pass_a, to_a, run_a}, 32'b000001);
    check_eq("rd_async_fin", {28'd0, fin_a}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("rd_restart3", cnt_a, 32'd3);
    finish_req = 4'b0001;
    tick(1);
    finish_req = 4'b0000;
    tick(4);
    check_eq("rd_cnt8", cnt_a, 32'd8);
    check_eq("rd_done", {30'd0, done_a, pass_a}, 32'b11);
    check_eq("rd_fin", {28'd0, fin_a}, 32'b0001);

    // Saturation on the 4-bit counter and direct-to-done with zero drain
    do_reset();
    hb_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (hb_c) hb_seen++;
    end
    check_eq("sat_cnt15", {28'd0, cnt_c}, 32'd15);
    check_eq("sat_no_hb", hb_seen, 32'd0);
    finish_req = 4'b1000;
    tick(1);
    finish_req = 4'b0000;
    check_eq("d0_cnt21", cnt_d, 32'd21);
    check_eq("d0_done", {27'd0, done_d, pass_d, drn_d, run_d, to_d}, 32'b11000);
    check_eq("d0_src", {24'd0, fin_d, fsrc_d}, 32'b10000000);
    check_eq("d0_hb", {31'd0, hb_d}, 32'd0);
    check_eq("sat_drain", {30'd0, drn_c, run_c}, 32'b10);
    tick(4);
    check_eq("sat_frozen", {28'd0, cnt_c}, 32'd15);
    check_eq("sat_done", {29'd0, done_c, pass_c, to_c}, 32'b110);
    check_eq("sat_src", {24'd0, fin_c, fsrc_c}, 32'b10000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
